uart_cmd_ctrl: RTL and testbench
================================

# uart_cmd_ctrl

Frame-level controller behind the UART receiver. Consumes the receiver's byte stream (`rx_data`/`rx_rdy`), hunts for a sync byte, and assembles 4-byte command frames (SYNC, ADDR, DATA, CHK). On a valid checksum it issues one register-write transaction with a valid/ack handshake. Sits between the UART receiver and the register file, on the receiver's bit clock.

## Interface
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `TIMEOUT`, default 40: maximum idle cycles between bytes of one frame. Must be ≥ 2.
- `clk` in 1: receiver bit clock, same clock as the UART receiver.
- `rst` in 1: asynchronous, active-high reset.
- `rx_data` in 8: received byte. Valid only while `rx_rdy` is high.
- `rx_rdy` in 1: single-cycle byte-valid pulse from the receiver.
- `wr_addr` out 8: register address. Stable while `wr_en` is high.
- `wr_data` out 8: register write data. Stable while `wr_en` is high.
- `wr_en` out 1: write request, held until acknowledged.
- `wr_ack` in 1: write accepted. Sampled only while `wr_en` is high.
- `err_crc` out 1: one-cycle pulse, checksum mismatch.
- `err_timeout` out 1: one-cycle pulse, inter-byte timeout.
- `err_ovf` out 1: one-cycle pulse, byte dropped during WRITE.
- `busy` out 1: high in every state except HUNT.
- `frame_cnt` out 8: count of completed writes. Wraps 8'hFF→8'h00.

## Operation
- **Reset values:**
  - All outputs 0.
  - State HUNT; internal address, data and timeout registers cleared.
  - Reset mid-frame or mid-write discards the frame; `wr_en` drops asynchronously.
- **HUNT:**
  - `rx_rdy` with `rx_data`==`SYNC_BYTE` → ADDR.
  - Any other byte is ignored silently.
- **ADDR:** `rx_rdy` → latch address → DATA. A byte equal to `SYNC_BYTE` is taken as an address; there is no resync.
- **DATA:** `rx_rdy` → latch data → CHK.
- **CHK:** `rx_rdy` → compare `rx_data` with (ADDR + DATA) mod 256, 8-bit wrap, carry discarded.
  - Match → WRITE.
  - Mismatch → `err_crc` pulse → HUNT.
- **WRITE:**
  - `wr_en` is high. Address and data are held.
  - `wr_ack` sampled high → `wr_en` low, `frame_cnt`+1 → HUNT.
  - An `rx_rdy` in WRITE drops the byte and pulses `err_ovf`. This includes a byte equal to `SYNC_BYTE`.
- **Timeout:**
  - Counter of width clog2(TIMEOUT+1), active in ADDR, DATA and CHK only.
  - Cleared on entry to ADDR and on every `rx_rdy`; increments otherwise.
  - On reaching TIMEOUT: `err_timeout` pulse → HUNT.
  - No timeout applies in HUNT or WRITE.
- **Simultaneous events:**
  - `rx_rdy` and a timeout in the same cycle: the byte wins; no error is raised.
  - `wr_ack` and `rx_rdy` in the same WRITE cycle: the write completes, the byte is dropped, and `err_ovf` pulses.
  - At most one error pulse is active per cycle.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- CHK byte's `rx_rdy` sampled at edge k → `wr_en`, `wr_addr` and `wr_data` valid from edge k+1.
- `wr_ack` sampled high at edge m → `wr_en` low from edge m+1; `frame_cnt` updates at edge m+1.
- Minimum write: `wr_en` high for 1 cycle, when `wr_ack` is already high.
- `err_crc` high for exactly the cycle after the bad CHK byte is sampled.
- Last `rx_rdy` at edge k with no further byte → `err_timeout` high in cycle k+TIMEOUT; state is HUNT from the same edge.
- A byte arriving in the cycle the FSM re-enters HUNT is evaluated as a HUNT byte.

## Structure
- Package `uart_pkg` holds:
  - the state encoding (HUNT, ADDR, DATA, CHK, WRITE);
  - the `SYNC_BYTE` default;
  - the frame length constant (4).
- Single module. The timeout counter and checksum adder are inline; no sub-module is warranted.

## Test plan
1. **Good frame:** A5 10 3C 4C, `wr_ack` high 3 cycles after `wr_en` → `wr_addr`=10, `wr_data`=3C, `wr_en` high 4 cycles, `frame_cnt`=1, no errors.
2. **Bad checksum:** A5 10 3C 00 → `err_crc` one-cycle pulse, `wr_en` never high, `frame_cnt` unchanged, `busy` low afterwards.
3. **Timeout:** A5 22, then idle → `err_timeout` at exactly 40 cycles after the 22 byte. A following A5 22 33 55 → write 22/33.
4. **Checksum wrap and hunt:** garbage 00 FF 7E then A5 F0 20 10 → checksum wraps, write F0/20, garbage ignored with no errors.
5. **Overflow:** hold `wr_ack` low, send A5 01 02 03 then byte A5 during WRITE → `err_ovf` pulse, `wr_en` still high. After ack the state is HUNT, with no frame started from the dropped A5.
6. **Reset mid-frame:** assert `rst` after A5 40, and separately during WRITE → all outputs 0 immediately. The next full frame A5 40 01 41 writes 40/01 and `frame_cnt`=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART command-frame controller: state encoding,
// default sync marker, frame geometry and the frame checksum.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_ADDR,
        ST_DATA,
        ST_CHK,
        ST_WRITE
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         FRAME_LEN     = 4;

    // 8-bit wrapping sum; the carry out is deliberately discarded.
    function automatic logic [7:0] frame_checksum(input logic [7:0] addr,
                                                  input logic [7:0] data);
        return addr + data;
    endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Byte stream in from the UART receiver and register-write handshake out.
interface uart_cmd_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       wr_ack;

    modport master (
        input  rx_data, rx_rdy, wr_ack,
        output wr_addr, wr_data, wr_en
    );

    modport slave (
        output rx_data, rx_rdy, wr_ack,
        input  wr_addr, wr_data, wr_en
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Frame-level controller: hunts for SYNC, collects ADDR/DATA/CHK, and issues
// one register write per frame whose checksum matches.
module uart_cmd_ctrl
    import uart_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int         TIMEOUT   = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_cmd_ctrl_if.master      bus,
    output logic                 err_crc,
    output logic                 err_timeout,
    output logic                 err_ovf,
    output logic                 busy,
    output logic [7:0]           frame_cnt
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_t          state;
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_HUNT;
            to_cnt      <= '0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            bus.wr_en   <= 1'b0;
            err_crc     <= 1'b0;
            err_timeout <= 1'b0;
            err_ovf     <= 1'b0;
            busy        <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            err_crc     <= 1'b0;
            err_timeout <= 1'b0;
            err_ovf     <= 1'b0;
            case (state)
                ST_HUNT: begin
                    if (bus.rx_rdy && bus.rx_data == SYNC_BYTE) begin
                        state  <= ST_ADDR;
                        to_cnt <= '0;
                        busy   <= 1'b1;
                    end
                end
                ST_ADDR, ST_DATA, ST_CHK: begin
                    // An arriving byte always beats a timeout on the same edge.
                    if (bus.rx_rdy) begin
                        to_cnt <= '0;
                        case (state)
                            ST_ADDR: begin
                                bus.wr_addr <= bus.rx_data;
                                state       <= ST_DATA;
                            end
                            ST_DATA: begin
                                bus.wr_data <= bus.rx_data;
                                state       <= ST_CHK;
                            end
                            default: begin
                                if (bus.rx_data == frame_checksum(bus.wr_addr, bus.wr_data)) begin
                                    bus.wr_en <= 1'b1;
                                    state     <= ST_WRITE;
                                end else begin
                                    err_crc <= 1'b1;
                                    busy    <= 1'b0;
                                    state   <= ST_HUNT;
                                end
                            end
                        endcase
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        to_cnt      <= '0;
                        state       <= ST_HUNT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_WRITE: begin
                    err_ovf <= bus.rx_rdy;
                    if (bus.wr_ack) begin
                        bus.wr_en <= 1'b0;
                        frame_cnt <= frame_cnt + 8'd1;
                        busy      <= 1'b0;
                        state     <= ST_HUNT;
                    end
                end
                default: begin
                    bus.wr_en <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_HUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with a byte-queue reference model and a
// per-cycle output comparison.
module tb_uart_cmd_ctrl;
    import uart_pkg::*;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         TO   = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       err_crc, err_timeout, err_ovf, busy;
    logic [7:0] frame_cnt;
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         t_last;
    bit         found;

    uart_cmd_ctrl_if bus();

    uart_cmd_ctrl #(.SYNC_BYTE(SYNC), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .err_crc     (err_crc),
        .err_timeout (err_timeout),
        .err_ovf     (err_ovf),
        .busy        (busy),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: bytes collected so far, a pending write, an idle count.
    logic [7:0] frame_q[$];
    bit         m_pend = 0;
    logic [7:0] m_addr = 0, m_data = 0, m_cnt = 0;
    int         m_idle = 0;
    bit         m_crc = 0, m_to = 0, m_ovf = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q.delete();
            m_pend = 0; m_addr = 0; m_data = 0; m_cnt = 0; m_idle = 0;
            m_crc = 0; m_to = 0; m_ovf = 0;
        end else begin
            m_crc = 0; m_to = 0; m_ovf = 0;
            if (m_pend) begin
                if (bus.rx_rdy) m_ovf = 1;
                if (bus.wr_ack) begin
                    m_pend = 0;
                    m_cnt  = m_cnt + 8'd1;
                end
            end else if (frame_q.size() == 0) begin
                if (bus.rx_rdy && bus.rx_data == SYNC) begin
                    frame_q.push_back(bus.rx_data);
                    m_idle = 0;
                end
            end else if (bus.rx_rdy) begin
                frame_q.push_back(bus.rx_data);
                m_idle = 0;
                if (frame_q.size() == FRAME_LEN) begin
                    if (((int'(frame_q[1]) + int'(frame_q[2])) % 256) == int'(frame_q[3])) begin
                        m_pend = 1;
                        m_addr = frame_q[1];
                        m_data = frame_q[2];
                    end else begin
                        m_crc = 1;
                    end
                    frame_q.delete();
                end
            end else begin
                m_idle++;
                if (m_idle == TO) begin
                    m_to = 1;
                    frame_q.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        automatic bit m_busy = m_pend || (frame_q.size() != 0);
        total++;
        if (bus.wr_en !== m_pend || err_crc !== m_crc || err_timeout !== m_to ||
            err_ovf !== m_ovf || busy !== m_busy || frame_cnt !== m_cnt) begin
            bad++;
            $display("FAIL ctrl @%0d: dut en=%b crc=%b to=%b ovf=%b busy=%b cnt=%0d, model en=%b crc=%b to=%b ovf=%b busy=%b cnt=%0d",
                     cyc, bus.wr_en, err_crc, err_timeout, err_ovf, busy, frame_cnt,
                     m_pend, m_crc, m_to, m_ovf, m_busy, m_cnt);
        end
        if (m_pend) begin
            total++;
            if (bus.wr_addr !== m_addr || bus.wr_data !== m_data) begin
                bad++;
                $display("FAIL wr_bus @%0d: dut addr=%h data=%h, model addr=%h data=%h",
                         cyc, bus.wr_addr, bus.wr_data, m_addr, m_data);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_rdy  = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_rdy  = 1'b0;
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send(SYNC); idle(1);
        send(a);    idle(1);
        send(d);    idle(1);
        send(c);
    endtask

    function automatic logic [31:0] all_outs();
        return {4'h0, bus.wr_addr, bus.wr_data, frame_cnt,
                bus.wr_en, err_crc, err_timeout, err_ovf};
    endfunction

    initial begin
        rst = 1'b1;
        bus.rx_data = 8'h00;
        bus.rx_rdy  = 1'b0;
        bus.wr_ack  = 1'b0;
        #12;
        chk("reset_outs", all_outs(), 32'h0);
        chk("reset_busy", busy, 0);
        #10 rst = 1'b0;
        @(posedge clk);
        #1;

        // Good frame, ack three cycles after wr_en rises.
        frame(8'h10, 8'h3C, 8'h4C);
        chk("good_wr_en", bus.wr_en, 1);
        chk("good_addr", bus.wr_addr, 8'h10);
        chk("good_data", bus.wr_data, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("good_hold", bus.wr_en, 1);
        end
        bus.wr_ack = 1'b1;
        idle(1);
        bus.wr_ack = 1'b0;
        chk("good_done_en", bus.wr_en, 0);
        chk("good_cnt", frame_cnt, 8'd1);

        // Bad checksum.
        idle(2);
        frame(8'h10, 8'h3C, 8'h00);
        chk("crc_pulse", err_crc, 1);
        chk("crc_no_wr", bus.wr_en, 0);
        idle(1);
        chk("crc_one_cycle", err_crc, 0);
        chk("crc_busy", busy, 0);
        chk("crc_cnt", frame_cnt, 8'd1);

        // Timeout exactly TIMEOUT cycles after the last byte.
        idle(2);
        send(SYNC); idle(1);
        send(8'h22);
        t_last = cyc;
        found  = 0;
        for (int i = 0; i < TO + 20 && !found; i++) begin
            @(negedge clk);
            if (err_timeout) found = 1;
        end
        chk("to_seen", found, 1);
        chk("to_delay", cyc - t_last, TO);
        chk("to_busy", busy, 0);
        @(posedge clk);
        #1;

        // Byte on the timeout edge wins, then the frame completes.
        send(SYNC); idle(1);
        send(8'h22); idle(TO - 1);
        send(8'h33);
        chk("race_no_to", err_timeout, 0);
        chk("race_busy", busy, 1);
        idle(1);
        send(8'h55);
        chk("to2_addr", bus.wr_addr, 8'h22);
        chk("to2_data", bus.wr_data, 8'h33);
        bus.wr_ack = 1'b1;
        idle(1);
        bus.wr_ack = 1'b0;
        chk("to2_cnt", frame_cnt, 8'd2);

        // Garbage then a frame whose checksum wraps; single-cycle write.
        send(8'h00); idle(1);
        send(8'hFF); idle(1);
        send(8'h7E); idle(1);
        chk("garbage_busy", busy, 0);
        frame(8'hF0, 8'h20, 8'h10);
        chk("wrap_en", bus.wr_en, 1);
        chk("wrap_addr", bus.wr_addr, 8'hF0);
        bus.wr_ack = 1'b1;
        idle(1);
        bus.wr_ack = 1'b0;
        chk("wrap_min_write", bus.wr_en, 0);
        chk("wrap_cnt", frame_cnt, 8'd3);

        // Overflow: SYNC byte dropped while the write is pending.
        frame(8'h01, 8'h02, 8'h03);
        idle(1);
        send(SYNC);
        chk("ovf_pulse", err_ovf, 1);
        chk("ovf_still_en", bus.wr_en, 1);
        idle(1);
        chk("ovf_one_cycle", err_ovf, 0);
        bus.wr_ack = 1'b1;
        idle(1);
        bus.wr_ack = 1'b0;
        chk("ovf_cnt", frame_cnt, 8'd4);
        send(8'h40);
        chk("ovf_no_frame", busy, 0);

        // Reset mid-frame, then reset during a write.
        idle(1);
        send(SYNC); idle(1);
        send(8'h40);
        #2 rst = 1'b1;
        #1;
        chk("rst_frame_outs", all_outs(), 32'h0);
        chk("rst_frame_busy", busy, 0);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        frame(8'h40, 8'h01, 8'h41);
        chk("rst_wr_pre", bus.wr_en, 1);
        #3 rst = 1'b1;
        #1;
        chk("rst_wr_outs", all_outs(), 32'h0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        frame(8'h40, 8'h01, 8'h41);
        chk("post_rst_addr", bus.wr_addr, 8'h40);
        chk("post_rst_data", bus.wr_data, 8'h01);
        bus.wr_ack = 1'b1;
        idle(1);
        bus.wr_ack = 1'b0;
        chk("post_rst_cnt", frame_cnt, 8'd1);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
